// File: rtl/bram_scan_ctrl.sv
// Sequential BRAM scanner: reads each byte, shows it on the display for a dwell period, then advances.
// Optional macro SCAN_WRAP_EN: when defined the scan restarts at address 0 instead of stopping in DONE.
module bram_scan_ctrl #(
  parameter int ADDR_W       = 10,
  parameter int LAST_ADDR    = 1023,
  parameter int DWELL_CYCLES = 100000000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              pause,
  input  logic              step,
  output logic              bram_en,
  output logic [ADDR_W-1:0] bram_addr,
  input  logic [7:0]        bram_dout,
  output logic [7:0]        disp_data,
  output logic [ADDR_W-1:0] disp_addr,
  output logic              disp_valid,
  output logic              busy,
  output logic              done
);

  localparam int CNT_W = $clog2(DWELL_CYCLES + 1);
  localparam logic [ADDR_W-1:0] ADDR_LAST  = ADDR_W'(LAST_ADDR);
  localparam logic [ADDR_W-1:0] ADDR_ONE   = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] ADDR_ZERO  = {ADDR_W{1'b0}};
  localparam logic [CNT_W-1:0]  CNT_LOAD   = CNT_W'(DWELL_CYCLES - 1);
  localparam logic [CNT_W-1:0]  CNT_ONE    = CNT_W'(1);
  localparam logic [CNT_W-1:0]  CNT_ZERO   = {CNT_W{1'b0}};

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_READ    = 3'd1,
    S_WAIT    = 3'd2,
    S_CAPTURE = 3'd3,
    S_DWELL   = 3'd4,
    S_DONE    = 3'd5
  } state_t;

  state_t             state_q, state_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [7:0]         disp_data_q, disp_data_d;
  logic [ADDR_W-1:0]  disp_addr_q, disp_addr_d;
  logic               bram_en_q, bram_en_d;
  logic               disp_valid_q, disp_valid_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               dwell_end_s;

  // Next-state, address/counter update and registered-output decode.
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    cnt_d       = cnt_q;
    dwell_end_s = 1'b0;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          addr_d  = ADDR_ZERO;
          state_d = S_READ;
        end else begin
          state_d = state_q;
        end
      end
      S_READ:    state_d = S_WAIT;
      S_WAIT:    state_d = S_CAPTURE;
      S_CAPTURE: begin
        cnt_d   = CNT_LOAD;
        state_d = S_DWELL;
      end
      S_DWELL: begin
        if (pause) begin
          dwell_end_s = step;
        end else if (cnt_q == CNT_ZERO) begin
          dwell_end_s = 1'b1;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
        if (dwell_end_s) begin
          if (addr_q == ADDR_LAST) begin
`ifdef SCAN_WRAP_EN
            addr_d  = ADDR_ZERO;
            state_d = S_READ;
`else
            state_d = S_DONE;
`endif
          end else begin
            addr_d  = addr_q + ADDR_ONE;
            state_d = S_READ;
          end
        end else begin
          state_d = S_DWELL;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Outputs are registered from the upcoming state so they line up with it.
    bram_en_d    = (state_d == S_READ);
    disp_valid_d = (state_q == S_CAPTURE);
    busy_d       = (state_d != S_IDLE) && (state_d != S_DONE);
    done_d       = (state_d == S_DONE);
    if (state_q == S_CAPTURE) begin
      disp_data_d = bram_dout;
      disp_addr_d = addr_q;
    end else begin
      disp_data_d = disp_data_q;
      disp_addr_d = disp_addr_q;
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      addr_q       <= ADDR_ZERO;
      cnt_q        <= CNT_ZERO;
      disp_data_q  <= 8'h00;
      disp_addr_q  <= ADDR_ZERO;
      bram_en_q    <= 1'b0;
      disp_valid_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      cnt_q        <= cnt_d;
      disp_data_q  <= disp_data_d;
      disp_addr_q  <= disp_addr_d;
      bram_en_q    <= bram_en_d;
      disp_valid_q <= disp_valid_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

  assign bram_en    = bram_en_q;
  assign bram_addr  = addr_q;
  assign disp_data  = disp_data_q;
  assign disp_addr  = disp_addr_q;
  assign disp_valid = disp_valid_q;
  assign busy       = busy_q;
  assign done       = done_q;

endmodule

// File: tb/tb_bram_scan_ctrl.sv
// Directed bench for bram_scan_ctrl with DWELL_CYCLES=4, LAST_ADDR=3 and a 4-byte BRAM model.
module tb_bram_scan_ctrl;
  localparam int AW = 10;

  logic          clk = 1'b0;
  logic          reset, start, pause, step;
  logic          bram_en;
  logic [AW-1:0] bram_addr;
  logic [7:0]    bram_dout = 8'h00;
  logic [7:0]    disp_data;
  logic [AW-1:0] disp_addr;
  logic          disp_valid, busy, done;

  logic [7:0] mem [4];
  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    logic          start;
    logic          pause;
    logic          step;
    logic          en;
    logic [AW-1:0] baddr;
    logic          valid;
    logic [7:0]    data;
    logic [AW-1:0] daddr;
    logic          busy;
    logic          done;
  } vec_t;
  vec_t tbl [30];

  bram_scan_ctrl #(.ADDR_W(AW), .LAST_ADDR(3), .DWELL_CYCLES(4)) dut (
    .clk(clk), .reset(reset), .start(start), .pause(pause), .step(step),
    .bram_en(bram_en), .bram_addr(bram_addr), .bram_dout(bram_dout),
    .disp_data(disp_data), .disp_addr(disp_addr), .disp_valid(disp_valid),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // One-cycle-latency BRAM model
  always @(posedge clk) begin
    if (bram_en) bram_dout <= (bram_addr < 10'd4) ? mem[bram_addr[1:0]] : 8'hEE;
  end

  function automatic logic [31:0] pk(logic en, logic [AW-1:0] ba, logic v, logic [7:0] d,
                                     logic [AW-1:0] da, logic b, logic dn);
    return {en, ba, v, d, da, b, dn};
  endfunction

  function automatic logic [31:0] outs();
    return pk(bram_en, bram_addr, disp_valid, disp_data, disp_addr, busy, done);
  endfunction

  task automatic check(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s[%0d]: got %h, expected %h", name, idx, act, exp);
    end
  endtask

  // Apply inputs for one clock edge, then return at the following falling edge.
  task automatic cyc(input logic r, input logic s, input logic p, input logic st);
    reset = r; start = s; pause = p; step = st;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 1'b1, 1'b1, 1'b1);
    check("reset_state", 0, outs(), 32'h0);
  endtask

  initial begin
    int cnt;
    logic got;
    mem[0] = 8'h10; mem[1] = 8'h21; mem[2] = 8'h32; mem[3] = 8'h43;
    reset = 1'b1; start = 1'b0; pause = 1'b0; step = 1'b0;

    // Expected trace for a full scan: 7 cycles per byte, display updates 3 cycles after READ
    for (int i = 0; i < 30; i++) begin
      int p, blk, a;
      p = i % 7; blk = i / 7; a = blk % 4;
      tbl[i].start = (i == 0); tbl[i].pause = 1'b0; tbl[i].step = 1'b0;
`ifndef SCAN_WRAP_EN
      if (i >= 28) begin
        tbl[i].en = 1'b0; tbl[i].baddr = 10'd3; tbl[i].valid = 1'b0;
        tbl[i].data = 8'h43; tbl[i].daddr = 10'd3; tbl[i].busy = 1'b0; tbl[i].done = 1'b1;
        continue;
      end
`endif
      tbl[i].en    = (p == 0);
      tbl[i].baddr = 10'(a);
      tbl[i].valid = (p == 3);
      if (p >= 3) begin
        tbl[i].data = mem[a]; tbl[i].daddr = 10'(a);
      end else if (blk == 0) begin
        tbl[i].data = 8'h00; tbl[i].daddr = 10'd0;
      end else begin
        tbl[i].data = mem[(blk - 1) % 4]; tbl[i].daddr = 10'((blk - 1) % 4);
      end
      tbl[i].busy = 1'b1; tbl[i].done = 1'b0;
    end

    @(negedge clk);
    do_reset();
    for (int i = 0; i < 30; i++) begin
      cyc(1'b0, tbl[i].start, tbl[i].pause, tbl[i].step);
      check("scan", i, outs(), pk(tbl[i].en, tbl[i].baddr, tbl[i].valid, tbl[i].data,
                                  tbl[i].daddr, tbl[i].busy, tbl[i].done));
    end

    // Pause from CAPTURE of address 1 for 20 cycles
    do_reset();
    cyc(1'b0, 1'b1, 1'b0, 1'b0);
    for (int k = 0; k < 9; k++) cyc(1'b0, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 20; k++) begin
      cyc(1'b0, 1'b0, 1'b1, 1'b0);
      check("pause_hold", k, {23'd0, bram_en, disp_data}, {23'd0, 1'b0, 8'h21});
    end
    cnt = 0; got = 1'b0;
    for (int k = 0; k < 10 && !got; k++) begin
      cyc(1'b0, 1'b0, 1'b0, 1'b0);
      cnt++;
      got = bram_en;
    end
    check("pause_release_cycles", 0, 32'(cnt), 32'd4);
    check("pause_next_addr", 0, {21'd0, got, bram_addr}, {21'd0, 1'b1, 10'd2});

    // Single step while paused in dwell of address 2
    do_reset();
    cyc(1'b0, 1'b1, 1'b0, 1'b0);
    for (int k = 0; k < 17; k++) cyc(1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b1, 1'b0);
    check("paused_no_read", 0, {31'd0, bram_en}, 32'd0);
    cyc(1'b0, 1'b0, 1'b1, 1'b1);
    check("step_read", 0, {21'd0, bram_en, bram_addr}, {21'd0, 1'b1, 10'd3});
    for (int k = 0; k < 2; k++) begin
      cyc(1'b0, 1'b0, 1'b0, 1'b0);
      check("step_no_valid_yet", k, {31'd0, disp_valid}, 32'd0);
    end
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    check("step_capture", 0, {13'd0, disp_valid, disp_data, disp_addr}, {13'd0, 1'b1, 8'h43, 10'd3});

    // Reset in the WAIT cycle of address 2
    do_reset();
    cyc(1'b0, 1'b1, 1'b0, 1'b0);
    for (int k = 0; k < 15; k++) cyc(1'b0, 1'b0, 1'b0, 1'b0);
    check("at_wait2", 0, {21'd0, bram_en, bram_addr}, {21'd0, 1'b0, 10'd2});
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    check("reset_in_wait", 0, outs(), 32'h0);
    for (int k = 0; k < 8; k++) begin
      cyc(1'b0, 1'b0, 1'b0, 1'b0);
      check("after_reset_idle", k, outs(), 32'h0);
    end

    // start held high for the whole scan
    do_reset();
    cyc(1'b0, 1'b1, 1'b0, 1'b0);
    for (int i = 1; i < 28; i++) begin
      cyc(1'b0, 1'b1, 1'b0, 1'b0);
      check("start_held", i, {20'd0, bram_en, bram_addr, busy},
            {20'd0, (i % 7) == 0, 10'(i / 7), 1'b1});
    end
    cyc(1'b0, 1'b1, 1'b0, 1'b0);
`ifdef SCAN_WRAP_EN
    check("wrap_read0", 0, {19'd0, bram_en, bram_addr, busy, done}, {19'd0, 1'b1, 10'd0, 1'b1, 1'b0});
`else
    check("done_entered", 0, {19'd0, bram_en, bram_addr, busy, done}, {19'd0, 1'b0, 10'd3, 1'b0, 1'b1});
    cyc(1'b0, 1'b1, 1'b0, 1'b0);
    check("restart_read0", 0, {19'd0, bram_en, bram_addr, busy, done}, {19'd0, 1'b1, 10'd0, 1'b1, 1'b0});
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
